mm2s_fb_scheduler: RTL and testbench
====================================

Name: mm2s_fb_scheduler

Overview:
- Frame-buffer scheduler for the MM2S frame reader.
- Tracks which DDR frame buffer the S2MM writer most recently completed and, on each reader frame_pulse, hands the reader the base address of the newest safe buffer.
- Sequences the reader's soft_resetn/fsync so that enable/disable happen only at clean frame boundaries.
- Sits between the register file, the S2MM writer status and the MM2S reader.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32: width of buffer addresses.
- C_BUF_IDX_BITS, 2: width of buffer index; up to 2**C_BUF_IDX_BITS buffers.
- C_CNT_BITS, 16: width of the statistics counters.

Ports:
- M_AXI_ACLK  in  1  clock.
- M_AXI_ARESET  in  1  asynchronous, active-high reset.
- enable  in  1  software run request (level).
- buf_base  in  C_M_AXI_ADDR_WIDTH  address of buffer 0.
- buf_stride  in  C_M_AXI_ADDR_WIDTH  byte distance between buffers.
- wr_done  in  1  one-cycle pulse: writer finished buffer wr_done_idx.
- wr_done_idx  in  C_BUF_IDX_BITS  index of the finished buffer.
- wr_busy  in  1  writer currently filling a buffer.
- wr_busy_idx  in  C_BUF_IDX_BITS  index of the buffer being filled.
- frame_pulse  in  1  reader is starting a frame (combinational from reader).
- resetting  in  1  reader soft-reset in progress.
- soft_resetn  out  1  reader soft reset, active-low.
- fsync  out  1  frame start permission to reader.
- base_addr  out  C_M_AXI_ADDR_WIDTH  base address for the next frame.
- rd_idx  out  C_BUF_IDX_BITS  buffer currently owned by the reader.
- frame_cnt  out  C_CNT_BITS  frames started (optional feature).
- repeat_cnt  out  C_CNT_BITS  frames re-read without new data (optional feature).

Behaviour:
- Reset values: soft_resetn=0, fsync=0, base_addr=0, rd_idx=0, frame_cnt=0, repeat_cnt=0, state=IDLE, latest_idx=0, new_flag=0, have_frame=0.
- Latest tracker:
  - On wr_done: latest_idx<=wr_done_idx, new_flag<=1, have_frame<=1.
  - Applies in every state except IDLE, where the tracker is held cleared.
- IDLE: soft_resetn=0, fsync=0. enable=1 -> WAIT.
- WAIT: soft_resetn=1, fsync=0.
  - have_frame=1 -> RUN.
  - enable=0 -> DRAIN.
- RUN: soft_resetn=1, fsync=1. A frame_pulse sampled high at edge N is a "take":
  - If new_flag=1 and not (wr_busy=1 and wr_busy_idx==latest_idx): rd_idx<=latest_idx, base_addr<=buf_base+latest_idx*buf_stride, new_flag<=0.
  - Otherwise rd_idx and base_addr are unchanged (repeat).
  - base_addr is valid from edge N, i.e. one cycle after frame_pulse; the reader loads it on its start_burst_pulse cycle.
  - enable=0 -> DRAIN; fsync drops immediately, no new take.
- DRAIN: soft_resetn=0, fsync=0.
  - Stay at least 2 cycles, because resetting rises one cycle after the soft_resetn negedge.
  - Then exit when resetting=0 -> IDLE.
  - enable reasserted while in DRAIN is ignored until IDLE is reached.
- Address arithmetic: index*stride is truncated to C_M_AXI_ADDR_WIDTH, added modulo 2**C_M_AXI_ADDR_WIDTH; no overflow flag.
- wr_done coinciding with a take: the take uses the pre-edge latest_idx (registered value). The new index is recorded and new_flag remains 1.
- wr_done_idx equal to the current rd_idx is accepted as-is; the writer guarantees exclusion.
- frame_pulse outside RUN is ignored.
- Asynchronous reset mid-frame returns all state to reset values immediately.

Optional Feature:
- Macro MM2S_SCHED_STAT_EN.
- Defined:
  - frame_cnt increments on every take.
  - repeat_cnt increments on every take that did not switch buffers.
  - Both wrap modulo 2**C_CNT_BITS.
  - Both are cleared in IDLE.
- Not defined: frame_cnt and repeat_cnt are constant 0 and no counter registers are instantiated.

Test Plan:
- Reset, enable=1, buf_base=0x1000_0000, buf_stride=0x0010_0000, wr_done idx=2, then frame_pulse -> state reaches RUN, fsync=1, base_addr=0x1020_0000 one cycle after frame_pulse, rd_idx=2.
- Second frame_pulse with no wr_done -> base_addr unchanged; repeat_cnt=1, frame_cnt=2 (MM2S_SCHED_STAT_EN).
- wr_done idx=1 in the same cycle as frame_pulse -> base_addr stays 0x1020_0000; next frame_pulse gives 0x1010_0000.
- new_flag set with latest_idx=0, wr_busy=1, wr_busy_idx=0, frame_pulse -> repeat taken, rd_idx unchanged; after wr_busy=0, next frame_pulse switches to idx 0.
- enable falls while RUN and resetting held high 5 cycles -> fsync=0 and soft_resetn=0 next cycle; IDLE entered the cycle after resetting=0; counters cleared.
- M_AXI_ARESET asserted mid-RUN, asynchronously between edges -> soft_resetn, fsync, base_addr go 0 without waiting for a clock edge.

Source files
------------

// File: rtl/mm2s_fb_scheduler_if.sv
// Signal bundle between the MM2S frame-buffer scheduler and its environment
// (register file, S2MM writer status, MM2S reader).
// master: the scheduler side. slave: the environment side.
interface mm2s_fb_scheduler_if #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_BUF_IDX_BITS     = 2,
    parameter int C_CNT_BITS         = 16
);
    logic                          enable;
    logic [C_M_AXI_ADDR_WIDTH-1:0] buf_base;
    logic [C_M_AXI_ADDR_WIDTH-1:0] buf_stride;
    logic                          wr_done;
    logic [C_BUF_IDX_BITS-1:0]     wr_done_idx;
    logic                          wr_busy;
    logic [C_BUF_IDX_BITS-1:0]     wr_busy_idx;
    logic                          frame_pulse;
    logic                          resetting;
    logic                          soft_resetn;
    logic                          fsync;
    logic [C_M_AXI_ADDR_WIDTH-1:0] base_addr;
    logic [C_BUF_IDX_BITS-1:0]     rd_idx;
    logic [C_CNT_BITS-1:0]         frame_cnt;
    logic [C_CNT_BITS-1:0]         repeat_cnt;

    modport master (
        input  enable, buf_base, buf_stride, wr_done, wr_done_idx,
               wr_busy, wr_busy_idx, frame_pulse, resetting,
        output soft_resetn, fsync, base_addr, rd_idx, frame_cnt, repeat_cnt
    );

    modport slave (
        output enable, buf_base, buf_stride, wr_done, wr_done_idx,
               wr_busy, wr_busy_idx, frame_pulse, resetting,
        input  soft_resetn, fsync, base_addr, rd_idx, frame_cnt, repeat_cnt
    );
endinterface

// File: rtl/mm2s_fb_scheduler.sv
// MM2S frame-buffer scheduler.
// Tracks the newest buffer completed by the S2MM writer and, on every reader
// frame_pulse, hands the reader the base address of the newest safe buffer.
// Sequences reader soft_resetn/fsync so enable/disable only happen at clean
// frame boundaries.
// Optional statistics counters: define MM2S_SCHED_STAT_EN.
module mm2s_fb_scheduler #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_BUF_IDX_BITS     = 2,
    parameter int C_CNT_BITS         = 16
) (
    input  logic               M_AXI_ACLK,
    input  logic               M_AXI_ARESET,
    mm2s_fb_scheduler_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RUN, S_DRAIN} state_t;

    state_t                        r_state;
    logic                          r_soft_resetn;
    logic                          r_fsync;
    logic [C_M_AXI_ADDR_WIDTH-1:0] r_base_addr;
    logic [C_BUF_IDX_BITS-1:0]     r_rd_idx;
    logic [C_BUF_IDX_BITS-1:0]     r_latest_idx;
    logic                          r_new_flag;
    logic                          r_have_frame;
    logic                          r_drain_min;   // minimum DRAIN dwell elapsed

    logic                          w_take;
    logic                          w_switch;
    logic [C_M_AXI_ADDR_WIDTH-1:0] w_idx_ext;
    logic [C_M_AXI_ADDR_WIDTH-1:0] w_next_addr;

    // A take is a frame start seen while running; a disable in the same
    // cycle wins, so no take happens on the way into DRAIN.
    assign w_take   = (r_state == S_RUN) && bus.enable && bus.frame_pulse;
    // Switch only to fresh data that the writer is not currently overwriting.
    assign w_switch = w_take && r_new_flag &&
                      !(bus.wr_busy && (bus.wr_busy_idx == r_latest_idx));

    // Address arithmetic wraps modulo 2**C_M_AXI_ADDR_WIDTH.
    assign w_idx_ext   = C_M_AXI_ADDR_WIDTH'(r_latest_idx);
    assign w_next_addr = bus.buf_base + (w_idx_ext * bus.buf_stride);

    // Control FSM, registered outputs and newest-buffer tracker.
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            r_state       <= S_IDLE;
            r_soft_resetn <= 1'b0;
            r_fsync       <= 1'b0;
            r_base_addr   <= '0;
            r_rd_idx      <= '0;
            r_latest_idx  <= '0;
            r_new_flag    <= 1'b0;
            r_have_frame  <= 1'b0;
            r_drain_min   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_soft_resetn <= 1'b0;
                    r_fsync       <= 1'b0;
                    r_latest_idx  <= '0;
                    r_new_flag    <= 1'b0;
                    r_have_frame  <= 1'b0;
                    if (bus.enable) begin
                        r_state       <= S_WAIT;
                        r_soft_resetn <= 1'b1;
                    end
                end
                S_WAIT: begin
                    // Disable takes priority so fsync never pulses on the way out.
                    if (!bus.enable) begin
                        r_state       <= S_DRAIN;
                        r_soft_resetn <= 1'b0;
                        r_drain_min   <= 1'b0;
                    end else if (r_have_frame) begin
                        r_state <= S_RUN;
                        r_fsync <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!bus.enable) begin
                        r_state       <= S_DRAIN;
                        r_soft_resetn <= 1'b0;
                        r_fsync       <= 1'b0;
                        r_drain_min   <= 1'b0;
                    end else if (w_switch) begin
                        r_rd_idx    <= r_latest_idx;
                        r_base_addr <= w_next_addr;
                        r_new_flag  <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    // resetting lags soft_resetn by a cycle, so dwell two cycles
                    // before trusting resetting=0.
                    if (!r_drain_min) begin
                        r_drain_min <= 1'b1;
                    end else if (!bus.resetting) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Writer completion overrides a same-cycle take's flag clear.
            if ((r_state != S_IDLE) && bus.wr_done) begin
                r_latest_idx <= bus.wr_done_idx;
                r_new_flag   <= 1'b1;
                r_have_frame <= 1'b1;
            end
        end
    end

    assign bus.soft_resetn = r_soft_resetn;
    assign bus.fsync       = r_fsync;
    assign bus.base_addr   = r_base_addr;
    assign bus.rd_idx      = r_rd_idx;

`ifdef MM2S_SCHED_STAT_EN
    logic [C_CNT_BITS-1:0] r_frame_cnt;
    logic [C_CNT_BITS-1:0] r_repeat_cnt;

    // Frames taken and frames re-read without new data; cleared while idle.
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            r_frame_cnt  <= '0;
            r_repeat_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_frame_cnt  <= '0;
            r_repeat_cnt <= '0;
        end else if (w_take) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
            if (!w_switch) begin
                r_repeat_cnt <= r_repeat_cnt + 1'b1;
            end
        end
    end

    assign bus.frame_cnt  = r_frame_cnt;
    assign bus.repeat_cnt = r_repeat_cnt;
`else
    assign bus.frame_cnt  = '0;
    assign bus.repeat_cnt = '0;
`endif
endmodule

// File: tb/tb_mm2s_fb_scheduler.sv
// Directed bench for mm2s_fb_scheduler with a take scoreboard.
// Counter expectations follow MM2S_SCHED_STAT_EN (zero when undefined).
module tb_mm2s_fb_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;

    mm2s_fb_scheduler_if #(.C_M_AXI_ADDR_WIDTH(32), .C_BUF_IDX_BITS(2), .C_CNT_BITS(16)) bus ();

    mm2s_fb_scheduler #(.C_M_AXI_ADDR_WIDTH(32), .C_BUF_IDX_BITS(2), .C_CNT_BITS(16)) dut (
        .M_AXI_ACLK  (clk),
        .M_AXI_ARESET(rst),
        .bus         (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  idx;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_frames = 0;
    int   exp_reps   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag);
`ifdef MM2S_SCHED_STAT_EN
        chk({tag, "_frame_cnt"},  32'(bus.frame_cnt),  32'(exp_frames));
        chk({tag, "_repeat_cnt"}, 32'(bus.repeat_cnt), 32'(exp_reps));
`else
        chk({tag, "_frame_cnt"},  32'(bus.frame_cnt),  32'd0);
        chk({tag, "_repeat_cnt"}, 32'(bus.repeat_cnt), 32'd0);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame_pulse cycle, optionally with a coincident wr_done.
    task automatic take(input string tag, input logic [31:0] ea, input logic [1:0] ei,
                        input bit rep, input bit wd, input logic [1:0] wdi);
        exp_t e;
        bus.frame_pulse = 1'b1;
        bus.wr_done     = wd;
        bus.wr_done_idx = wdi;
        e.addr = ea;
        e.idx  = ei;
        sb.push_back(e);
        exp_frames++;
        if (rep) exp_reps++;
        tick();
        bus.frame_pulse = 1'b0;
        bus.wr_done     = 1'b0;
        chk({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_base_addr"}, bus.base_addr, e.addr);
            chk({tag, "_rd_idx"}, 32'(bus.rd_idx), 32'(e.idx));
            $display("take %s: base_addr=0x%08h rd_idx=%0d", tag, bus.base_addr, bus.rd_idx);
        end
        chk_cnt(tag);
    endtask

    task automatic writer_done(input logic [1:0] idx);
        bus.wr_done     = 1'b1;
        bus.wr_done_idx = idx;
        tick();
        bus.wr_done     = 1'b0;
    endtask

    initial begin
        bus.enable      = 1'b0;
        bus.buf_base    = 32'h1000_0000;
        bus.buf_stride  = 32'h0010_0000;
        bus.wr_done     = 1'b0;
        bus.wr_done_idx = '0;
        bus.wr_busy     = 1'b0;
        bus.wr_busy_idx = '0;
        bus.frame_pulse = 1'b0;
        bus.resetting   = 1'b0;

        // Reset state, before any clock edge.
        #2;
        chk("rst_soft_resetn", 32'(bus.soft_resetn), 32'd0);
        chk("rst_fsync", 32'(bus.fsync), 32'd0);
        chk("rst_base_addr", bus.base_addr, 32'd0);
        chk("rst_rd_idx", 32'(bus.rd_idx), 32'd0);
        chk_cnt("rst");
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("idle_soft_resetn", 32'(bus.soft_resetn), 32'd0);

        // Enable -> WAIT.
        bus.enable = 1'b1;
        tick();
        chk("wait_soft_resetn", 32'(bus.soft_resetn), 32'd1);
        chk("wait_fsync", 32'(bus.fsync), 32'd0);

        // frame_pulse outside RUN is ignored.
        bus.frame_pulse = 1'b1;
        tick();
        bus.frame_pulse = 1'b0;
        chk("wait_pulse_base_addr", bus.base_addr, 32'd0);
        chk("wait_pulse_fsync", 32'(bus.fsync), 32'd0);
        chk_cnt("wait_pulse");

        // First completed buffer -> RUN.
        writer_done(2'd2);
        tick();
        chk("run_fsync", 32'(bus.fsync), 32'd1);
        chk("run_soft_resetn", 32'(bus.soft_resetn), 32'd1);

        take("t1_switch_idx2",    32'h1020_0000, 2'd2, 1'b0, 1'b0, 2'd0);
        take("t2_repeat",         32'h1020_0000, 2'd2, 1'b1, 1'b0, 2'd0);
        take("t3_coincident_wd1", 32'h1020_0000, 2'd2, 1'b1, 1'b1, 2'd1);
        take("t4_switch_idx1",    32'h1010_0000, 2'd1, 1'b0, 1'b0, 2'd0);

        // Newest buffer still being written -> repeat; then switch once free.
        writer_done(2'd0);
        bus.wr_busy     = 1'b1;
        bus.wr_busy_idx = 2'd0;
        take("t5_busy_repeat",    32'h1010_0000, 2'd1, 1'b1, 1'b0, 2'd0);
        bus.wr_busy     = 1'b0;
        take("t6_switch_idx0",    32'h1000_0000, 2'd0, 1'b0, 1'b0, 2'd0);

        // Coincident wr_done while new data pending: take old latest, keep new pending.
        writer_done(2'd3);
        take("t7_coincident_new", 32'h1030_0000, 2'd3, 1'b0, 1'b1, 2'd2);
        take("t8_pending_kept",   32'h1020_0000, 2'd2, 1'b0, 1'b0, 2'd0);

        // Address wraps modulo 2**32.
        writer_done(2'd3);
        bus.buf_base   = 32'hF000_0000;
        bus.buf_stride = 32'h8000_0000;
        take("t9_addr_wrap",      32'h7000_0000, 2'd3, 1'b0, 1'b0, 2'd0);
        bus.buf_base   = 32'h1000_0000;
        bus.buf_stride = 32'h0010_0000;

        // Disable: outputs drop next cycle; DRAIN held while resetting is high.
        bus.enable = 1'b0;
        tick();
        chk("drain_fsync", 32'(bus.fsync), 32'd0);
        chk("drain_soft_resetn", 32'(bus.soft_resetn), 32'd0);
        bus.resetting = 1'b1;
        bus.enable    = 1'b1;   // ignored until IDLE
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("drain_hold%0d_soft_resetn", i), 32'(bus.soft_resetn), 32'd0);
        end
        bus.resetting = 1'b0;
        tick();   // DRAIN -> IDLE
        chk("drain_exit_soft_resetn", 32'(bus.soft_resetn), 32'd0);
        tick();   // IDLE -> WAIT (enable still high)
        exp_frames = 0;
        exp_reps   = 0;
        chk("rewait_soft_resetn", 32'(bus.soft_resetn), 32'd1);
        chk("rewait_fsync", 32'(bus.fsync), 32'd0);
        chk_cnt("idle_cleared");

        // Tracker was cleared in IDLE: no RUN without a fresh completion.
        tick();
        chk("rewait_no_frame_fsync", 32'(bus.fsync), 32'd0);
        writer_done(2'd1);
        tick();
        chk("rerun_fsync", 32'(bus.fsync), 32'd1);
        take("t10_after_restart", 32'h1010_0000, 2'd1, 1'b0, 1'b0, 2'd0);

        // Asynchronous reset between edges.
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_soft_resetn", 32'(bus.soft_resetn), 32'd0);
        chk("async_rst_fsync", 32'(bus.fsync), 32'd0);
        chk("async_rst_base_addr", bus.base_addr, 32'd0);
        chk("async_rst_rd_idx", 32'(bus.rd_idx), 32'd0);
        exp_frames = 0;
        exp_reps   = 0;
        chk_cnt("async_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
